// File: rtl/tx_frame_fifo_pkg.sv
// Shared MAC transmit-path definitions: AXIS data geometry and the frame-buffer write FSM states.
package tx_frame_fifo_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned DATA_NBYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WRITE,
    WR_DROP
  } wr_state_e;

endpackage

// File: rtl/tx_frame_fifo_sdp_ram.sv
// Simple-dual-port RAM: one write port, one registered read port, no reset on the array.
module tx_frame_fifo_sdp_ram #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 512,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata holds its value while re is low; the prefetch logic relies on that.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/tx_frame_fifo.sv
// Store-and-forward transmit frame buffer: a frame is released to the MAC only once fully
// buffered; overflowing or user-marked bad frames are discarded.
module tx_frame_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512,
  localparam int unsigned DATA_NBYTES = DATA_WIDTH / 8,
  localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  s00_axis_tdata,
  input  logic [DATA_NBYTES-1:0] s00_axis_tkeep,
  input  logic                   s00_axis_tvalid,
  output logic                   s00_axis_tready,
  input  logic                   s00_axis_tlast,
  input  logic                   s00_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
  output logic [DATA_NBYTES-1:0] m00_axis_tkeep,
  output logic                   m00_axis_tvalid,
  input  logic                   m00_axis_tready,
  output logic                   m00_axis_tlast,
  output logic                   frame_dropped,
  output logic [ADDR_W:0]        fill_level
);

  import tx_frame_fifo_pkg::*;

  localparam int unsigned ENTRY_W = DATA_WIDTH + DATA_NBYTES + 1;
  localparam logic [ADDR_W:0] DEPTH_PTR = (ADDR_W + 1)'(DEPTH);

  wr_state_e state_q, state_d;

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] wr_start_q, wr_start_d;
  logic [ADDR_W:0] wr_commit_q, wr_commit_d;
  logic [ADDR_W:0] rd_ptr_q;
  logic [ADDR_W:0] rd_addr_q;

  logic ready_en_q;
  logic dropped_q, dropped_d;
  logic full;
  logic accept;
  logic wr_en;

  logic               pop;
  logic               mid_move;
  logic               rd_en;
  logic               mid_vld_q;
  logic [ENTRY_W-1:0] ram_rdata;

  logic                   out_vld_q;
  logic                   out_last_q;
  logic [DATA_NBYTES-1:0] out_keep_q;
  logic [DATA_WIDTH-1:0]  out_data_q;

  // rd_ptr only advances when the MAC takes a beat, so prefetched words still count as occupied.
  assign full       = (wr_ptr_q - rd_ptr_q) == DEPTH_PTR;
  assign fill_level = wr_ptr_q - rd_ptr_q;

  // ---------------------------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE: begin
        if (accept && !s00_axis_tlast) begin
          state_d = WR_WRITE;
        end
      end
      WR_WRITE: begin
        if (accept) begin
          if (s00_axis_tlast) begin
            state_d = WR_IDLE;
          end else if (full) begin
            state_d = WR_DROP;
          end
        end
      end
      WR_DROP: begin
        if (accept && s00_axis_tlast) begin
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    s00_axis_tready = 1'b0;
    accept          = 1'b0;
    wr_en           = 1'b0;
    dropped_d       = 1'b0;
    wr_ptr_d        = wr_ptr_q;
    wr_start_d      = wr_start_q;
    wr_commit_d     = wr_commit_q;
    case (state_q)
      WR_IDLE: begin
        s00_axis_tready = ready_en_q && !full;
        accept          = s00_axis_tvalid && s00_axis_tready;
        if (accept) begin
          wr_start_d = wr_ptr_q;
          if (s00_axis_tlast && s00_axis_tuser) begin
            dropped_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s00_axis_tlast) begin
              wr_commit_d = wr_ptr_q + 1'b1;
            end
          end
        end
      end
      WR_WRITE: begin
        s00_axis_tready = ready_en_q;
        accept          = s00_axis_tvalid && s00_axis_tready;
        if (accept) begin
          if (full) begin
            // Frame cannot fit: rewind and swallow the rest of it.
            wr_ptr_d  = wr_start_q;
            dropped_d = s00_axis_tlast;
          end else if (s00_axis_tlast && s00_axis_tuser) begin
            wr_ptr_d  = wr_start_q;
            dropped_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s00_axis_tlast) begin
              wr_commit_d = wr_ptr_q + 1'b1;
            end
          end
        end
      end
      WR_DROP: begin
        s00_axis_tready = ready_en_q;
        accept          = s00_axis_tvalid && s00_axis_tready;
        dropped_d       = accept && s00_axis_tlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      wr_start_q  <= '0;
      wr_commit_q <= '0;
      dropped_q   <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_start_q  <= wr_start_d;
      wr_commit_q <= wr_commit_d;
      dropped_q   <= dropped_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign frame_dropped = dropped_q;

  // ---------------------------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------------------------
  tx_frame_fifo_sdp_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata ({s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata}),
    .re    (rd_en),
    .raddr (rd_addr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------------------------------
  // Read side: RAM output register plus output register form a 2-entry FWFT prefetch.
  // ---------------------------------------------------------------------------------------------
  assign pop      = out_vld_q && m00_axis_tready;
  assign mid_move = mid_vld_q && (!out_vld_q || pop);
  assign rd_en    = (rd_addr_q != wr_commit_q) && (!mid_vld_q || mid_move);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q  <= '0;
      rd_ptr_q   <= '0;
      mid_vld_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_keep_q <= '0;
      out_data_q <= '0;
    end else begin
      if (rd_en) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      mid_vld_q <= rd_en || (mid_vld_q && !mid_move);
      if (mid_move) begin
        out_vld_q                              <= 1'b1;
        {out_last_q, out_keep_q, out_data_q}   <= ram_rdata;
      end else if (pop) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign m00_axis_tvalid = out_vld_q;
  assign m00_axis_tlast  = out_last_q;
  assign m00_axis_tkeep  = out_keep_q;
  assign m00_axis_tdata  = out_data_q;

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Scoreboard bench for tx_frame_fifo: a default-depth instance and a 16-deep instance share stimulus.
module tb_tx_frame_fifo;

  typedef logic [36:0] beat_t;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  always #5 clk = ~clk;

  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tvalid, s_tlast, s_tuser, m_tready;

  logic        bg_tready, bg_mvalid, bg_mlast, bg_drop;
  logic [31:0] bg_mdata;
  logic [3:0]  bg_mkeep;
  logic [9:0]  bg_fill;

  logic        sm_tready, sm_mvalid, sm_mlast, sm_drop;
  logic [31:0] sm_mdata;
  logic [3:0]  sm_mkeep;
  logic [4:0]  sm_fill;

  logic        cur_tready, cur_mvalid, cur_mlast, cur_drop;
  logic [31:0] cur_mdata;
  logic [3:0]  cur_mkeep;
  logic [9:0]  cur_fill;

  tx_frame_fifo #(.DATA_WIDTH(32), .DEPTH(512)) u_big (
    .clk(clk), .reset(reset),
    .s00_axis_tdata(s_tdata), .s00_axis_tkeep(s_tkeep), .s00_axis_tvalid(s_tvalid && !sel),
    .s00_axis_tready(bg_tready), .s00_axis_tlast(s_tlast), .s00_axis_tuser(s_tuser),
    .m00_axis_tdata(bg_mdata), .m00_axis_tkeep(bg_mkeep), .m00_axis_tvalid(bg_mvalid),
    .m00_axis_tready(m_tready), .m00_axis_tlast(bg_mlast),
    .frame_dropped(bg_drop), .fill_level(bg_fill)
  );

  tx_frame_fifo #(.DATA_WIDTH(32), .DEPTH(16)) u_small (
    .clk(clk), .reset(reset),
    .s00_axis_tdata(s_tdata), .s00_axis_tkeep(s_tkeep), .s00_axis_tvalid(s_tvalid && sel),
    .s00_axis_tready(sm_tready), .s00_axis_tlast(s_tlast), .s00_axis_tuser(s_tuser),
    .m00_axis_tdata(sm_mdata), .m00_axis_tkeep(sm_mkeep), .m00_axis_tvalid(sm_mvalid),
    .m00_axis_tready(m_tready), .m00_axis_tlast(sm_mlast),
    .frame_dropped(sm_drop), .fill_level(sm_fill)
  );

  assign cur_tready = sel ? sm_tready : bg_tready;
  assign cur_mvalid = sel ? sm_mvalid : bg_mvalid;
  assign cur_mlast  = sel ? sm_mlast  : bg_mlast;
  assign cur_mkeep  = sel ? sm_mkeep  : bg_mkeep;
  assign cur_mdata  = sel ? sm_mdata  : bg_mdata;
  assign cur_drop   = sel ? sm_drop   : bg_drop;
  assign cur_fill   = sel ? {5'b0, sm_fill} : bg_fill;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    drop_cnt = 0;
  bit    sm_seen_valid = 0;

  always @(negedge clk) begin
    if (bg_drop) drop_cnt++;
    if (sm_drop) drop_cnt++;
    if (sm_mvalid) sm_seen_valid = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic u);
    int guard;
    guard    = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    while (!cur_tready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got tready=0 exp tready=1 within 100 cycles");
    end
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [3:0] last_keep, input logic user,
                            input logic expect_pass, input logic [31:0] base);
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    for (int i = 0; i < len; i++) begin
      d = base + 32'(i) * 32'h0101_0101;
      l = (i == len - 1);
      k = l ? last_keep : 4'hF;
      if (expect_pass) exp_q.push_back({l, k, d});
      send_beat(d, k, l, l ? user : 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic drain(input int max_cyc, input bit toggle, output int n);
    beat_t cur, prev, exp;
    bit    started, prev_stall;
    started    = 0;
    prev_stall = 0;
    prev       = '0;
    n          = 0;
    for (int c = 0; c < max_cyc && exp_q.size() > 0; c++) begin
      m_tready = toggle ? (c % 2 == 0) : 1'b1;
      cur = {cur_mlast, cur_mkeep, cur_mdata};
      if (prev_stall) begin
        checks++;
        if (cur_mvalid !== 1'b1 || cur !== prev) begin
          errors++;
          $display("FAIL stall_hold got v=%b %h exp v=1 %h", cur_mvalid, cur, prev);
        end
      end
      if (started) begin
        checks++;
        if (cur_mvalid !== 1'b1) begin
          errors++;
          $display("FAIL tvalid_gap got tvalid=%b exp tvalid=1", cur_mvalid);
        end
      end
      if (cur_mvalid === 1'b1) started = 1;
      if (cur_mvalid === 1'b1 && m_tready) begin
        exp = exp_q.pop_front();
        n++;
        checks++;
        if (cur !== exp) begin
          errors++;
          $display("FAIL beat got %h exp %h", cur, exp);
        end
      end
      prev_stall = (cur_mvalid === 1'b1) && !m_tready;
      prev       = cur;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d beats left exp 0", exp_q.size());
    end
  endtask

  task automatic check_fill(input string name, input int exp);
    checks++;
    if (int'(cur_fill) != exp) begin
      errors++;
      $display("FAIL %s fill_level got %0d exp %0d", name, cur_fill, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bg_tready, bg_mvalid, bg_mlast, bg_mkeep, bg_mdata, bg_drop, bg_fill} !== '0) begin
      errors++;
      $display("FAIL reset_big got rdy=%b v=%b l=%b k=%h d=%h drop=%b fill=%0d exp all 0",
               bg_tready, bg_mvalid, bg_mlast, bg_mkeep, bg_mdata, bg_drop, bg_fill);
    end
    checks++;
    if ({sm_tready, sm_mvalid, sm_mlast, sm_mkeep, sm_mdata, sm_drop, sm_fill} !== '0) begin
      errors++;
      $display("FAIL reset_small got rdy=%b v=%b fill=%0d exp all 0",
               sm_tready, sm_mvalid, sm_fill);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bg_tready, sm_tready} !== 2'b00) begin
      errors++;
      $display("FAIL tready_before_edge got %b exp 00", {bg_tready, sm_tready});
    end
    @(negedge clk);
    checks++;
    if ({bg_tready, sm_tready} !== 2'b11) begin
      errors++;
      $display("FAIL tready_after_edge got %b exp 11", {bg_tready, sm_tready});
    end
  endtask

  task automatic test_single();
    int n;
    sel      = 1'b0;
    m_tready = 1'b1;
    send_frame(16, 4'h3, 1'b0, 1'b1, 32'hA000_0000);
    check_fill("single_after_tlast", 16);
    checks++;
    if (cur_mvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n0 got tvalid=%b exp 0", cur_mvalid);
    end
    @(negedge clk);
    checks++;
    if (cur_mvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1 got tvalid=%b exp 0", cur_mvalid);
    end
    @(negedge clk);
    checks++;
    if (cur_mvalid !== 1'b1) begin
      errors++;
      $display("FAIL latency_n2 got tvalid=%b exp 1", cur_mvalid);
    end
    drain(100, 1'b0, n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL single_count got %0d exp 16", n);
    end
    @(negedge clk);
    check_fill("single_empty", 0);
  endtask

  task automatic test_stall_toggle();
    int n;
    sel      = 1'b0;
    m_tready = 1'b0;
    send_frame(16, 4'h3, 1'b0, 1'b1, 32'hA000_0000);
    repeat (3) @(negedge clk);
    drain(200, 1'b1, n);
    m_tready = 1'b0;
    @(negedge clk);
    check_fill("toggle_empty", 0);
  endtask

  task automatic test_back_to_back();
    int n;
    sel      = 1'b0;
    m_tready = 1'b0;
    send_frame(20, 4'hF, 1'b0, 1'b1, 32'h1000_0000);
    send_frame(20, 4'h7, 1'b0, 1'b1, 32'h2000_0000);
    send_frame(20, 4'h1, 1'b0, 1'b1, 32'h3000_0000);
    repeat (3) @(negedge clk);
    check_fill("b2b_committed", 60);
    drain(200, 1'b0, n);
    checks++;
    if (n != 60) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 60", n);
    end
    m_tready = 1'b0;
  endtask

  task automatic test_bad_frame();
    int n, d0;
    sel      = 1'b0;
    m_tready = 1'b0;
    send_frame(3, 4'hF, 1'b0, 1'b1, 32'h4000_0000);
    repeat (2) @(negedge clk);
    check_fill("bad_before", 3);
    d0 = drop_cnt;
    send_frame(8, 4'hF, 1'b1, 1'b0, 32'h5000_0000);
    repeat (2) @(negedge clk);
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++;
      $display("FAIL bad_drop_pulses got %0d exp 1", drop_cnt - d0);
    end
    check_fill("bad_after", 3);
    send_frame(5, 4'h3, 1'b0, 1'b1, 32'h6000_0000);
    repeat (3) @(negedge clk);
    drain(100, 1'b0, n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL bad_follow_count got %0d exp 8", n);
    end
    m_tready = 1'b0;
  endtask

  task automatic test_full();
    int    n;
    beat_t cur, exp;
    sel      = 1'b1;
    m_tready = 1'b0;
    send_frame(16, 4'hF, 1'b0, 1'b1, 32'h7000_0000);
    repeat (2) @(negedge clk);
    checks++;
    if (cur_tready !== 1'b0) begin
      errors++;
      $display("FAIL full_tready got %b exp 0", cur_tready);
    end
    check_fill("full_level", 16);
    cur      = {cur_mlast, cur_mkeep, cur_mdata};
    m_tready = 1'b1;
    checks++;
    if (cur_mvalid !== 1'b1) begin
      errors++;
      $display("FAIL full_head_valid got %b exp 1", cur_mvalid);
    end
    @(negedge clk);
    m_tready = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (cur !== exp) begin
      errors++;
      $display("FAIL full_release_beat got %h exp %h", cur, exp);
    end
    checks++;
    if (cur_tready !== 1'b1) begin
      errors++;
      $display("FAIL full_release_tready got %b exp 1", cur_tready);
    end
    drain(100, 1'b0, n);
    m_tready = 1'b0;
  endtask

  task automatic test_overflow();
    int n, d0;
    sel           = 1'b1;
    m_tready      = 1'b1;
    sm_seen_valid = 1'b0;
    d0            = drop_cnt;
    send_frame(20, 4'hF, 1'b0, 1'b0, 32'h8000_0000);
    repeat (4) @(negedge clk);
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ovf_drop_pulses got %0d exp 1", drop_cnt - d0);
    end
    checks++;
    if (sm_seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_output got tvalid seen=%b exp 0", sm_seen_valid);
    end
    check_fill("ovf_fill", 0);
    send_frame(4, 4'h1, 1'b0, 1'b1, 32'h9000_0000);
    drain(50, 1'b0, n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL ovf_follow_count got %0d exp 4", n);
    end
    m_tready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n, d0;
    sel      = 1'b0;
    m_tready = 1'b0;
    send_frame(4, 4'h7, 1'b0, 1'b1, 32'hB000_0000);
    repeat (3) @(negedge clk);
    checks++;
    if (cur_mvalid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre_valid got %b exp 1", cur_mvalid);
    end
    for (int i = 0; i < 6; i++) send_beat(32'hC000_0000 + 32'(i), 4'hF, 1'b0, 1'b0);
    check_fill("rmid_buffered", 10);
    s_tvalid = 1'b1;
    d0       = drop_cnt;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bg_tready, bg_mvalid, bg_mlast, bg_mkeep, bg_mdata, bg_drop, bg_fill} !== '0) begin
      errors++;
      $display("FAIL rmid_async got rdy=%b v=%b l=%b k=%h d=%h drop=%b fill=%0d exp all 0",
               bg_tready, bg_mvalid, bg_mlast, bg_mkeep, bg_mdata, bg_drop, bg_fill);
    end
    exp_q.delete();
    s_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (drop_cnt != d0) begin
      errors++;
      $display("FAIL rmid_no_pulse got %0d pulses exp 0", drop_cnt - d0);
    end
    send_frame(4, 4'h3, 1'b0, 1'b1, 32'hD000_0000);
    drain(50, 1'b0, n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rmid_follow_count got %0d exp 4", n);
    end
    @(negedge clk);
    check_fill("rmid_empty", 0);
  endtask

  initial begin
    reset    = 1'b1;
    sel      = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b0;
    test_reset();
    test_single();
    test_stall_toggle();
    test_back_to_back();
    test_bad_frame();
    test_full();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
